ifu_fetch_ctrl: RTL and testbench

- Fetch sequencer for the instruction fetch unit.
- Drives the IFU control inputs (PC set, PC source mux, instruction-memory valid, IR set) and consumes its ready/hit outputs.
- Hands fetched instructions to decode through a valid/stall handshake and applies branch redirects.
- Sits between the IFU and the decode/branch logic inside the core top level.

---
 rtl/ifu_fetch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_ctrl
// Description : Fetch sequencer driving the IFU and handing instructions to
//               decode. Optional performance counters are enabled with the
//               FETCH_CTRL_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl #(
  parameter int MAX_WAIT_CYCLES = 64,
  parameter int WAIT_CNT_WIDTH  = 8
) (
  input  logic       fetch_ctrl_clock_in,
  input  logic       fetch_ctrl_reset_in,
  input  logic       ins_mem_ready_in,
  input  logic       ins_mem_hit_in,
  input  logic       redirect_valid_in,
  input  logic       stall_in,
  output logic       pc_set_ctrl_out,
  output logic [1:0] pc_src_mux_ctrl_out,
  output logic       ins_mem_valid_ctrl_out,
  output logic       ir_set_ctrl_out,
  output logic       fetch_valid_out,
  output logic       redirect_ack_out,
  output logic       fetch_error_out
`ifdef FETCH_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_out,
  output logic [31:0] perf_miss_cnt_out
`endif
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    REDIR = 3'd4,
    ERROR = 3'd5
  } state_e;

  localparam logic [1:0] SRC_PC4   = 2'b00;
  localparam logic [1:0] SRC_REDIR = 2'b01;
  localparam logic [1:0] SRC_RESET = 2'b10;

  localparam logic [WAIT_CNT_WIDTH:0] MAX_WAIT = (WAIT_CNT_WIDTH+1)'(MAX_WAIT_CYCLES);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                      pend_redir_q, pend_redir_d;

  logic                      mem_hit;
  logic                      cnt_sat;
  logic [WAIT_CNT_WIDTH:0]   cnt_inc;

  assign mem_hit = ins_mem_ready_in & ins_mem_hit_in;
  assign cnt_sat = &wait_cnt_q;
  // One bit wider so the timeout compare stays correct at saturation.
  assign cnt_inc = {1'b0, wait_cnt_q} + {{WAIT_CNT_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge fetch_ctrl_clock_in) begin
    if (fetch_ctrl_reset_in) begin
      state_q      <= BOOT;
      wait_cnt_q   <= '0;
      pend_redir_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_redir_q <= pend_redir_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    wait_cnt_d             = wait_cnt_q;
    pend_redir_d           = pend_redir_q;
    pc_set_ctrl_out        = 1'b0;
    pc_src_mux_ctrl_out    = SRC_PC4;
    ins_mem_valid_ctrl_out = 1'b0;
    ir_set_ctrl_out        = 1'b0;
    fetch_valid_out        = 1'b0;
    redirect_ack_out       = 1'b0;
    fetch_error_out        = 1'b0;

    case (state_q)
      BOOT: begin
        pc_set_ctrl_out     = 1'b1;
        pc_src_mux_ctrl_out = SRC_RESET;
        state_d             = REQ;
      end
      REQ: begin
        ins_mem_valid_ctrl_out = 1'b1;
        wait_cnt_d             = '0;
        state_d                = WAIT;
      end
      WAIT: begin
        ins_mem_valid_ctrl_out = 1'b1;
        if (!cnt_sat) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (redirect_valid_in) begin
          pend_redir_d = 1'b1;
        end
        // A hit racing a redirect still writes IR, but is squashed via REDIR.
        if (mem_hit) begin
          ir_set_ctrl_out = 1'b1;
          state_d         = (pend_redir_q || redirect_valid_in) ? REDIR : ISSUE;
        end else if (cnt_inc >= MAX_WAIT) begin
          state_d = ERROR;
        end
      end
      ISSUE: begin
        if (redirect_valid_in) begin
          pc_set_ctrl_out     = 1'b1;
          pc_src_mux_ctrl_out = SRC_REDIR;
          redirect_ack_out    = 1'b1;
          state_d             = REQ;
        end else if (stall_in) begin
          fetch_valid_out = 1'b1;
        end else begin
          fetch_valid_out     = 1'b1;
          pc_set_ctrl_out     = 1'b1;
          pc_src_mux_ctrl_out = SRC_PC4;
          state_d             = REQ;
        end
      end
      REDIR: begin
        pc_set_ctrl_out     = 1'b1;
        pc_src_mux_ctrl_out = SRC_REDIR;
        redirect_ack_out    = 1'b1;
        pend_redir_d        = 1'b0;
        state_d             = REQ;
      end
      ERROR: begin
        fetch_error_out = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // While reset is held only the boot PC load may be visible.
    if (fetch_ctrl_reset_in) begin
      ins_mem_valid_ctrl_out = 1'b0;
      ir_set_ctrl_out        = 1'b0;
      fetch_valid_out        = 1'b0;
      redirect_ack_out       = 1'b0;
      fetch_error_out        = 1'b0;
      if (state_q != BOOT) begin
        pc_set_ctrl_out     = 1'b0;
        pc_src_mux_ctrl_out = SRC_PC4;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_miss_q;
  logic        fetch_done;
  logic        miss_seen;

  assign fetch_done = (state_q == ISSUE) && fetch_valid_out && !stall_in;
  assign miss_seen  = (state_q == WAIT) && ins_mem_ready_in && !ins_mem_hit_in;

  always_ff @(posedge fetch_ctrl_clock_in) begin
    if (fetch_ctrl_reset_in) begin
      perf_fetch_q <= '0;
      perf_miss_q  <= '0;
    end else begin
      if (fetch_done) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (miss_seen) begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_out = perf_fetch_q;
  assign perf_miss_cnt_out  = perf_miss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_ctrl
// Description : Directed vector bench for ifu_fetch_ctrl (default and short
//               timeout instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic hit = 1'b0;
  logic rdr = 1'b0;
  logic stl = 1'b0;

  logic       m_pcs, m_imv, m_irs, m_fv, m_ack, m_err;
  logic [1:0] m_src;
  logic       t_pcs, t_imv, t_irs, t_fv, t_ack, t_err;
  logic [1:0] t_src;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef FETCH_CTRL_PERF_CNT_EN
  logic [31:0] m_pf, m_pm, t_pf, t_pm;
`endif

  ifu_fetch_ctrl #(.MAX_WAIT_CYCLES(64), .WAIT_CNT_WIDTH(8)) dut (
    .fetch_ctrl_clock_in   (clk),
    .fetch_ctrl_reset_in   (rst),
    .ins_mem_ready_in      (rdy),
    .ins_mem_hit_in        (hit),
    .redirect_valid_in     (rdr),
    .stall_in              (stl),
    .pc_set_ctrl_out       (m_pcs),
    .pc_src_mux_ctrl_out   (m_src),
    .ins_mem_valid_ctrl_out(m_imv),
    .ir_set_ctrl_out       (m_irs),
    .fetch_valid_out       (m_fv),
    .redirect_ack_out      (m_ack),
    .fetch_error_out       (m_err)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .perf_fetch_cnt_out    (m_pf),
    .perf_miss_cnt_out     (m_pm)
`endif
  );

  ifu_fetch_ctrl #(.MAX_WAIT_CYCLES(4), .WAIT_CNT_WIDTH(8)) dut_to (
    .fetch_ctrl_clock_in   (clk),
    .fetch_ctrl_reset_in   (rst),
    .ins_mem_ready_in      (rdy),
    .ins_mem_hit_in        (hit),
    .redirect_valid_in     (rdr),
    .stall_in              (stl),
    .pc_set_ctrl_out       (t_pcs),
    .pc_src_mux_ctrl_out   (t_src),
    .ins_mem_valid_ctrl_out(t_imv),
    .ir_set_ctrl_out       (t_irs),
    .fetch_valid_out       (t_fv),
    .redirect_ack_out      (t_ack),
    .fetch_error_out       (t_err)
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    .perf_fetch_cnt_out    (t_pf),
    .perf_miss_cnt_out     (t_pm)
`endif
  );

  // Packed output view: {pc_set, src[1:0], mem_valid, ir_set, fetch_valid, ack, error}
  logic [7:0] w_main, w_to;
  assign w_main = {m_pcs, m_src, m_imv, m_irs, m_fv, m_ack, m_err};
  assign w_to   = {t_pcs, t_src, t_imv, t_irs, t_fv, t_ack, t_err};

  localparam logic [7:0] E_BOOT  = 8'b1_10_00000;
  localparam logic [7:0] E_REQ   = 8'b0_00_10000;
  localparam logic [7:0] E_WAIT  = 8'b0_00_10000;
  localparam logic [7:0] E_HIT   = 8'b0_00_11000;
  localparam logic [7:0] E_GO    = 8'b1_00_00100;
  localparam logic [7:0] E_STALL = 8'b0_00_00100;
  localparam logic [7:0] E_REDIR = 8'b1_01_00010;
  localparam logic [7:0] E_ZERO  = 8'b0_00_00000;
  localparam logic [7:0] E_ERR   = 8'b0_00_00001;

  // Inputs packed as {rst, ready, hit, redirect, stall}
  typedef struct {
    string      name;
    logic [4:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [4:0] in, input logic [7:0] exp);
    vec_t v;
    v.name = n;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic check8(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

`ifdef FETCH_CTRL_PERF_CNT_EN
  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
`endif

  task automatic drive(input logic [4:0] in);
    {rst, rdy, hit, rdr, stl} = in;
  endtask

  initial begin
    add("rst_boot",        5'b11100, E_BOOT);
    add("boot",            5'b01100, E_BOOT);
    add("req",             5'b01100, E_REQ);
    add("wait_hit",        5'b01100, E_HIT);
    add("issue",           5'b01100, E_GO);
    add("req2",            5'b01000, E_REQ);
    for (int k = 0; k < 5; k++) add("miss", 5'b01000, E_WAIT);
    add("miss_then_hit",   5'b01100, E_HIT);
    for (int k = 0; k < 3; k++) add("stall", 5'b01101, E_STALL);
    add("unstall",         5'b01100, E_GO);
    add("req3",            5'b00000, E_REQ);
    add("wait_idle",       5'b00000, E_WAIT);
    add("hit3",            5'b01100, E_HIT);
    add("stall2",          5'b00001, E_STALL);
    add("redir_in_stall",  5'b00011, E_REDIR);
    add("req4",            5'b00000, E_REQ);
    add("wait_redir",      5'b00010, E_WAIT);
    add("wait_redir_miss", 5'b01010, E_WAIT);
    add("squash_hit",      5'b01110, E_HIT);
    add("redir_state",     5'b00010, E_REDIR);
    add("req5",            5'b00000, E_REQ);
    add("redir_and_hit",   5'b01110, E_HIT);
    add("redir_state2",    5'b00010, E_REDIR);
    add("req_redir_ign",   5'b00010, E_REQ);
    add("hit_no_pend",     5'b01100, E_HIT);
    add("issue_go",        5'b00000, E_GO);
    add("req6",            5'b00000, E_REQ);
    add("rst_mid_fetch",   5'b11100, E_ZERO);
    add("boot_redir_ign",  5'b00010, E_BOOT);
    add("req7",            5'b00000, E_REQ);

    drive(5'b10000);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      @(negedge clk);
      check8(vecs[i].name, w_main, vecs[i].exp);
`ifdef FETCH_CTRL_PERF_CNT_EN
      if (i == 12) begin
        check32("perf_miss_after_5", m_pm, 32'd5);
        check32("perf_fetch_first", m_pf, 32'd1);
      end
      if (i == 33) begin
        check32("perf_fetch_total", m_pf, 32'd3);
        check32("perf_miss_total", m_pm, 32'd6);
      end
      if (i == 34) begin
        check32("perf_fetch_reset", m_pf, 32'd0);
        check32("perf_miss_reset", m_pm, 32'd0);
      end
`endif
      @(posedge clk);
      #1;
    end

    // Timeout on the short-wait instance.
    drive(5'b10000);
    repeat (2) @(posedge clk);
    #1;
    drive(5'b00000);
    @(negedge clk); check8("to_boot", w_to, E_BOOT);
    @(posedge clk); #1;
    @(negedge clk); check8("to_req", w_to, E_REQ);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check8("to_wait", w_to, E_WAIT);
      @(posedge clk); #1;
    end
    drive(5'b01110);
    @(negedge clk);
    check8("to_error", w_to, E_ERR);
    check8("main_no_timeout", w_main, E_HIT);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); check8("to_error_sticky", w_to, E_ERR);
      @(posedge clk); #1;
    end
    drive(5'b10000);
    @(negedge clk); check8("to_error_in_reset", w_to, E_ZERO);
    @(posedge clk); #1;
    drive(5'b00000);
    @(negedge clk); check8("to_boot_after_err", w_to, E_BOOT);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
